// File: rtl/pdes_pkg.sv
// pdes_pkg: shared definitions for the PHOLD event controller.
//   state_t      run state encoding
//   msg_bus_t    wide message carrier; messages are zero-extended into it
//                so the helpers below work for any MSG_WID <= MSG_MAX
//   anti_bit/lp_lsb   field offsets derived from TIME_WID / LP_WID
//   is_null_msg  anti flag set with lp == 0 and time == 0
//   msg_time     timestamp field, zero-extended
package pdes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  localparam int MSG_MAX = 64;
  typedef logic [MSG_MAX-1:0] msg_bus_t;

  localparam int TIME_LSB = 0;

  function automatic int lp_lsb(input int tw);
    return tw;
  endfunction

  function automatic int anti_bit(input int tw, input int lw);
    return tw + lw;
  endfunction

  function automatic logic is_null_msg(input msg_bus_t m, input int tw, input int lw);
    msg_bus_t low_mask;
    low_mask = (msg_bus_t'(1) << anti_bit(tw, lw)) - msg_bus_t'(1);
    return m[anti_bit(tw, lw)] && ((m & low_mask) == '0);
  endfunction

  function automatic msg_bus_t msg_time(input msg_bus_t m, input int tw);
    return (m >> TIME_LSB) & ((msg_bus_t'(1) << tw) - msg_bus_t'(1));
  endfunction

endpackage

// File: rtl/pdes_rr_arb.sv
// pdes_rr_arb: round-robin arbiter with an internal rotating pointer.
//   clk, reset  clock, async active-high reset (pointer -> 0)
//   req         request vector
//   advance     grant is consumed; pointer moves to gnt_idx+1 when a grant exists
//   gnt         one-hot grant (search starts at the pointer)
//   gnt_idx     index of the granted requester
//   any         a grant exists this cycle
module pdes_rr_arb #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic [IDX_W-1:0] ptr;
  int               idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!any && req[idx]) begin
        any          = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= '0;
    else if (advance && any)
      ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDX_W'(1);
  end

endmodule

// File: rtl/pdes_event_ctrl.sv
// pdes_event_ctrl: run controller for the PHOLD PDES engine.
//   Seeds one event per LP, moves new events from cores into the external
//   priority queue, dispatches queue head to idle cores round-robin, tracks a
//   monotonic GVT and drains cores before signalling done.
// Ports:
//   clk, reset        clock, async active-high reset
//   start / done / busy   run control; done is a one-cycle pulse
//   gvt, gvt_regress  global virtual time, sticky regress flag
//   core_ready, disp_vld, disp_msg                dispatch side
//   core_new_vld, core_new_msg, core_new_ack      receive side
//   q_enq, q_enq_msg, q_deq, q_head, q_empty, q_full   priority queue
//   min_time, min_time_vld   minimum timestamp of active cores
//   stat_disp, stat_enq, stat_null   counters when PDES_STATS_EN is defined,
//                                    otherwise tied to 0
module pdes_event_ctrl
  import pdes_pkg::*;
#(
  parameter int NUM_CORE     = 4,
  parameter int NUM_LP       = 8,
  parameter int TIME_WID     = 16,
  parameter int MSG_WID      = 32,
  parameter int SIM_END_TIME = 16000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        done,
  output logic                        busy,
  output logic [TIME_WID-1:0]         gvt,
  output logic                        gvt_regress,
  input  logic [NUM_CORE-1:0]         core_ready,
  output logic [NUM_CORE-1:0]         disp_vld,
  output logic [MSG_WID-1:0]          disp_msg,
  input  logic [NUM_CORE-1:0]         core_new_vld,
  input  logic [NUM_CORE*MSG_WID-1:0] core_new_msg,
  output logic [NUM_CORE-1:0]         core_new_ack,
  output logic                        q_enq,
  output logic [MSG_WID-1:0]          q_enq_msg,
  output logic                        q_deq,
  input  logic [MSG_WID-1:0]          q_head,
  input  logic                        q_empty,
  input  logic                        q_full,
  input  logic [TIME_WID-1:0]         min_time,
  input  logic                        min_time_vld,
  output logic [31:0]                 stat_disp,
  output logic [31:0]                 stat_enq,
  output logic [31:0]                 stat_null
);

  localparam int LP_WID = $clog2(NUM_LP);
  localparam int IDX_W  = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
  localparam int LP_LSB = lp_lsb(TIME_WID);

  state_t             state;
  logic [LP_WID-1:0]  seed_cnt;
  logic [MSG_WID-1:0] seed_msg;

  logic               active;
  logic [NUM_CORE-1:0] rx_req, rx_gnt, dp_req, dp_gnt;
  logic [IDX_W-1:0]   rx_idx, dp_idx_unused;
  logic               rx_any, dp_any;
  logic [MSG_WID-1:0] rx_msg;
  msg_bus_t           rx_w, head_w, mt_w, gvt_w, cand_w;
  logic               rx_null, cand_vld, cand_ge;

  assign busy   = (state != ST_IDLE);
  assign active = (state == ST_RUN) || (state == ST_DRAIN);

  // Receive wins the single queue slot; a full queue blocks receive so that
  // dispatch can still pop and break the full/pending-event deadlock.
  assign rx_req = (active && !q_full) ? core_new_vld : '0;
  assign dp_req = (state == ST_RUN && !q_empty && !rx_any) ? core_ready : '0;

  pdes_rr_arb #(.NUM_REQ(NUM_CORE)) u_rx_arb (
    .clk(clk), .reset(reset), .req(rx_req), .advance(1'b1),
    .gnt(rx_gnt), .gnt_idx(rx_idx), .any(rx_any)
  );

  pdes_rr_arb #(.NUM_REQ(NUM_CORE)) u_dp_arb (
    .clk(clk), .reset(reset), .req(dp_req), .advance(1'b1),
    .gnt(dp_gnt), .gnt_idx(dp_idx_unused), .any(dp_any)
  );

  assign rx_msg = core_new_msg[int'(rx_idx)*MSG_WID +: MSG_WID];

  always_comb begin
    seed_msg = '0;
    seed_msg[LP_LSB +: LP_WID] = seed_cnt;
  end

  // GVT candidate handled in the wide message carrier so full-width compares
  // need no truncation.
  always_comb begin
    rx_w   = '0;
    head_w = '0;
    mt_w   = '0;
    gvt_w  = '0;
    rx_w[MSG_WID-1:0]    = rx_msg;
    head_w[MSG_WID-1:0]  = q_head;
    mt_w[TIME_WID-1:0]   = min_time;
    gvt_w[TIME_WID-1:0]  = gvt;
    rx_null  = is_null_msg(rx_w, TIME_WID, LP_WID);
    cand_vld = min_time_vld || !q_empty;
    if (min_time_vld && !q_empty)
      cand_w = (mt_w < msg_time(head_w, TIME_WID)) ? mt_w : msg_time(head_w, TIME_WID);
    else if (min_time_vld)
      cand_w = mt_w;
    else
      cand_w = msg_time(head_w, TIME_WID);
    cand_ge = (cand_w >= gvt_w);
  end

  always_comb begin
    core_new_ack = '0;
    q_enq        = 1'b0;
    q_enq_msg    = '0;
    q_deq        = 1'b0;
    disp_vld     = '0;
    disp_msg     = '0;
    case (state)
      ST_INIT: begin
        if (!q_full) begin
          q_enq     = 1'b1;
          q_enq_msg = seed_msg;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (rx_any) begin
          core_new_ack = rx_gnt;
          if (!rx_null) begin
            q_enq     = 1'b1;
            q_enq_msg = rx_msg;
          end
        end else if (dp_any) begin
          disp_vld = dp_gnt;
          disp_msg = q_head;
          q_deq    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      gvt         <= '0;
      gvt_regress <= 1'b0;
      seed_cnt    <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_INIT;
            gvt         <= '0;
            gvt_regress <= 1'b0;
            seed_cnt    <= '0;
          end
        end
        ST_INIT: begin
          if (!q_full) begin
            seed_cnt <= seed_cnt + LP_WID'(1);
            if (seed_cnt == LP_WID'(NUM_LP - 1))
              state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (gvt > TIME_WID'(SIM_END_TIME))
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (&core_ready && !(|core_new_vld)) begin
            state <= ST_FINISH;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (active && cand_vld) begin
        if (cand_ge)
          gvt <= cand_w[TIME_WID-1:0];
        else
          gvt_regress <= 1'b1;
      end
    end
  end

`ifdef PDES_STATS_EN
  logic [31:0] cnt_disp, cnt_enq, cnt_null;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_disp <= '0;
      cnt_enq  <= '0;
      cnt_null <= '0;
    end else if (state == ST_IDLE && start) begin
      cnt_disp <= '0;
      cnt_enq  <= '0;
      cnt_null <= '0;
    end else begin
      if (q_deq && cnt_disp != '1)
        cnt_disp <= cnt_disp + 32'd1;
      if (q_enq && active && cnt_enq != '1)
        cnt_enq <= cnt_enq + 32'd1;
      if (rx_any && rx_null && cnt_null != '1)
        cnt_null <= cnt_null + 32'd1;
    end
  end

  assign stat_disp = cnt_disp;
  assign stat_enq  = cnt_enq;
  assign stat_null = cnt_null;
`else
  assign stat_disp = '0;
  assign stat_enq  = '0;
  assign stat_null = '0;
`endif

endmodule

// File: tb/tb_pdes_event_ctrl.sv
module tb_pdes_event_ctrl;

  localparam int N    = 4;
  localparam int NLP  = 8;
  localparam int TW   = 16;
  localparam int MW   = 32;
  localparam int SEND = 16000;
  localparam int ANTI = TW + 3;
  localparam logic [MW-1:0] LOW_MASK = (32'd1 << ANTI) - 32'd1;
  localparam logic [MW-1:0] NULL_MSG = 32'd1 << ANTI;

  localparam int P_IDLE = 0, P_INIT = 1, P_RUN = 2, P_DRAIN = 3, P_FIN = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic done, busy, gvt_regress, q_enq, q_deq;
  logic [TW-1:0] gvt;
  logic [N-1:0] core_ready = '0, core_new_vld = '0;
  logic [N-1:0] disp_vld, core_new_ack;
  logic [MW-1:0] disp_msg, q_enq_msg;
  logic [N*MW-1:0] core_new_msg = '0;
  logic [MW-1:0] q_head = '0;
  logic q_empty = 1'b1, q_full = 1'b0;
  logic [TW-1:0] min_time = '0;
  logic min_time_vld = 1'b0;
  logic [31:0] stat_disp, stat_enq, stat_null;

  int checks = 0;
  int errors = 0;

  logic [MW-1:0] enq_log[$];
  logic [N-1:0]  disp_log[$];

  pdes_event_ctrl #(.NUM_CORE(N), .NUM_LP(NLP), .TIME_WID(TW), .MSG_WID(MW),
                    .SIM_END_TIME(SEND)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
    .gvt(gvt), .gvt_regress(gvt_regress), .core_ready(core_ready),
    .disp_vld(disp_vld), .disp_msg(disp_msg), .core_new_vld(core_new_vld),
    .core_new_msg(core_new_msg), .core_new_ack(core_new_ack), .q_enq(q_enq),
    .q_enq_msg(q_enq_msg), .q_deq(q_deq), .q_head(q_head), .q_empty(q_empty),
    .q_full(q_full), .min_time(min_time), .min_time_vld(min_time_vld),
    .stat_disp(stat_disp), .stat_enq(stat_enq), .stat_null(stat_null)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase = P_IDLE, m_gvt = 0, m_cnt = 0, m_rx = 0, m_dp = 0;
  bit m_reg = 0;
  int n_phase = P_IDLE, n_gvt = 0, n_cnt = 0, n_rx = 0, n_dp = 0;
  bit n_reg = 0;
  int m_sd = 0, m_se = 0, m_sn = 0, n_sd = 0, n_se = 0, n_sn = 0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  logic [N-1:0]  e_ack, e_disp;
  logic          e_enq, e_deq;
  logic [MW-1:0] e_emsg, e_dmsg, m_msg;
  int g, d, cand;
  bit cv;

  always @(negedge clk) begin
    if (reset) begin
      m_phase = P_IDLE; m_gvt = 0; m_reg = 0; m_cnt = 0; m_rx = 0; m_dp = 0;
      m_sd = 0; m_se = 0; m_sn = 0;
    end
    e_ack = '0; e_disp = '0; e_enq = 0; e_deq = 0; e_emsg = '0; e_dmsg = '0;
    n_phase = m_phase; n_gvt = m_gvt; n_reg = m_reg; n_cnt = m_cnt;
    n_rx = m_rx; n_dp = m_dp; n_sd = m_sd; n_se = m_se; n_sn = m_sn;
    case (m_phase)
      P_IDLE: if (start) begin
        n_phase = P_INIT; n_gvt = 0; n_reg = 0; n_cnt = 0;
        n_sd = 0; n_se = 0; n_sn = 0;
      end
      P_INIT: if (!q_full) begin
        e_enq = 1; e_emsg = MW'(m_cnt) << TW; n_cnt = m_cnt + 1;
        if (m_cnt == NLP - 1) n_phase = P_RUN;
      end
      P_RUN, P_DRAIN: begin
        g = q_full ? -1 : pick(core_new_vld, m_rx);
        d = pick(core_ready, m_dp);
        if (g >= 0) begin
          e_ack[g] = 1; n_rx = (g + 1) % N;
          m_msg = core_new_msg[g*MW +: MW];
          if (m_msg[ANTI] && (m_msg & LOW_MASK) == 0) n_sn = m_sn + 1;
          else begin e_enq = 1; e_emsg = m_msg; n_se = m_se + 1; end
        end else if (m_phase == P_RUN && !q_empty && d >= 0) begin
          e_disp[d] = 1; e_dmsg = q_head; e_deq = 1; n_dp = (d + 1) % N;
          n_sd = m_sd + 1;
        end
        cv = min_time_vld || !q_empty;
        if (min_time_vld && !q_empty)
          cand = (int'(min_time) < int'(q_head[TW-1:0])) ? int'(min_time) : int'(q_head[TW-1:0]);
        else if (min_time_vld) cand = int'(min_time);
        else cand = int'(q_head[TW-1:0]);
        if (cv) begin
          if (cand >= m_gvt) n_gvt = cand; else n_reg = 1;
        end
        if (m_phase == P_RUN && m_gvt > SEND) n_phase = P_DRAIN;
        if (m_phase == P_DRAIN && core_ready == '1 && core_new_vld == '0) n_phase = P_FIN;
      end
      default: n_phase = P_IDLE;
    endcase
    chk("busy", busy, m_phase != P_IDLE);
    chk("done", done, m_phase == P_FIN);
    chk("gvt", gvt, m_gvt);
    chk("gvt_regress", gvt_regress, m_reg);
    chk("ack", core_new_ack, e_ack);
    chk("q_enq", q_enq, e_enq);
    chk("q_enq_msg", q_enq_msg, e_emsg);
    chk("q_deq", q_deq, e_deq);
    chk("disp_vld", disp_vld, e_disp);
    chk("disp_msg", disp_msg, e_dmsg);
`ifdef PDES_STATS_EN
    chk("stat_disp", stat_disp, m_sd);
    chk("stat_enq", stat_enq, m_se);
    chk("stat_null", stat_null, m_sn);
`else
    chk("stat_disp", stat_disp, 0);
    chk("stat_enq", stat_enq, 0);
    chk("stat_null", stat_null, 0);
`endif
    if (q_enq) enq_log.push_back(q_enq_msg);
    if (|disp_vld) disp_log.push_back(disp_vld);
  end

  always @(posedge clk) begin
    if (!reset) begin
      m_phase = n_phase; m_gvt = n_gvt; m_reg = n_reg; m_cnt = n_cnt;
      m_rx = n_rx; m_dp = n_dp; m_sd = n_sd; m_se = n_se; m_sn = n_sn;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_seeds(input string nm);
    int t;
    t = 0;
    while (enq_log.size() < NLP && t < 40) begin cyc(); t++; end
    chk({nm, "_count"}, enq_log.size(), NLP);
    for (int i = 0; i < NLP && i < enq_log.size(); i++)
      chk({nm, "_msg"}, enq_log[i], 64'(i) << 16);
  endtask

  logic [N-1:0] rr_exp[8];

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_gvt", gvt, 0);
    chk("rst_done", done, 0);

    // seeding, no back-pressure
    enq_log.delete();
    start = 1'b1; cyc(); start = 1'b0;
    wait_seeds("seed_a");
    chk("run_busy", busy, 1);

    // round-robin dispatch
    disp_log.delete();
    q_head = 32'd5; q_empty = 1'b0; core_ready = 4'hF;
    repeat (8) cyc();
    q_empty = 1'b1; core_ready = '0;
    chk("rr_count", disp_log.size(), 8);
    for (int i = 0; i < 8 && i < disp_log.size(); i++)
      chk("rr_seq", disp_log[i], rr_exp[i]);

    // receive priority and null drop
    core_new_vld = 4'b0100; core_new_msg[2*MW +: MW] = NULL_MSG;
    core_ready = 4'b0001; q_empty = 1'b0;
    #2;
    chk("null_ack", core_new_ack, 4'b0100);
    chk("null_enq", q_enq, 0);
    chk("null_disp", disp_vld, 0);
    cyc();
    core_new_vld = '0;
    #2;
    chk("after_null_disp", disp_vld, 4'b0001);
    chk("after_null_deq", q_deq, 1);
    chk("after_null_msg", disp_msg, 32'd5);
    cyc();

    // full queue with pending event: dispatch must still happen
    q_full = 1'b1; core_new_vld = 4'b0001; core_new_msg[0 +: MW] = 32'h0001_0033;
    core_ready = 4'b0010;
    #2;
    chk("dl_deq", q_deq, 1);
    chk("dl_disp", disp_vld, 4'b0010);
    chk("dl_ack", core_new_ack, 0);
    cyc();
    q_full = 1'b0; core_new_vld = '0; core_ready = '0;

    // a real (non-null) receive enqueues the slice
    core_new_vld = 4'b1000; core_new_msg[3*MW +: MW] = 32'h0005_0007;
    #2;
    chk("rx_enq", q_enq, 1);
    chk("rx_msg", q_enq_msg, 32'h0005_0007);
    cyc();
    core_new_vld = '0;

    // GVT tracking and regress
    q_head = 32'd90; q_empty = 1'b0; min_time = 16'd100; min_time_vld = 1'b1;
    cyc();
    chk("gvt_90", gvt, 90);
    min_time = 16'd80;
    cyc();
    chk("gvt_hold", gvt, 90);
    chk("gvt_regress_set", gvt_regress, 1);
    min_time_vld = 1'b0; q_empty = 1'b1;

    // termination
    min_time = 16'd16001; min_time_vld = 1'b1;
    cyc();
    chk("gvt_end", gvt, 16001);
    cyc();
    q_head = 32'd16001; q_empty = 1'b0; core_ready = 4'b0111;
    #2;
    chk("drain_no_disp", disp_vld, 0);
    chk("drain_busy", busy, 1);
    cyc();
    core_ready = 4'hF;
    cyc();
    chk("fin_done", done, 1);
    cyc();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    min_time_vld = 1'b0; q_empty = 1'b1; core_ready = '0;

    // restart clears regress; seeding with a 3-cycle full stall
    enq_log.delete();
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_regress", gvt_regress, 0);
    chk("restart_gvt", gvt, 0);
    repeat (3) cyc();
    q_full = 1'b1;
    repeat (3) cyc();
    chk("stall_count", enq_log.size(), 3);
    q_full = 1'b0;
    wait_seeds("seed_b");

    // reset mid-run
    cyc();
    reset = 1'b1;
    #2;
    chk("midrst_busy", busy, 0);
    cyc();
    reset = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
